cordic_pipe: RTL and testbench

//  Parametrised, fully pipelined CORDIC engine; successor of the fixed 16-iteration combinational cosine unit.

---
 rtl/cordic_pkg.sv | 54 +++++
 rtl/cordic_stage.sv | 83 ++++++++
 rtl/cordic_pipe.sv | 173 +++++++++++++++++
 tb/tb_cordic_pipe.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// ============================================================================
//  Module      : cordic_pkg
//  Description : Shared types, constants and the arctangent table for the
//                pipelined CORDIC engine (cordic_pipe / cordic_stage).
//                Optional feature macro: CORDIC_VECTOR_EN (vectoring mode).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cordic_pkg;

  // 1/K in Q2.30; pre-scaling x by this yields unit-amplitude cos/sin
  localparam logic [31:0] CORDIC_INV_GAIN_Q30 = 32'h26DD3B6A;

  typedef enum logic {
    CORDIC_ROT = 1'b0,
    CORDIC_VEC = 1'b1
  } cordic_mode_e;

  // round(atan(2^-i) * 2^angle_w / 2pi). The base table is held at 32-bit
  // phase resolution and rescaled (with rounding) to the requested width.
  function automatic logic [63:0] atan_lut(input int i, input int angle_w);
    logic [31:0] t;
    logic [63:0] v;
    case (i)
      0:  t = 32'h20000000;  1:  t = 32'h12E4051E;
      2:  t = 32'h09FB385B;  3:  t = 32'h051111D4;
      4:  t = 32'h028B0D43;  5:  t = 32'h0145D7E1;
      6:  t = 32'h00A2F61E;  7:  t = 32'h00517C55;
      8:  t = 32'h0028BE53;  9:  t = 32'h00145F2F;
      10: t = 32'h000A2F98;  11: t = 32'h000517CC;
      12: t = 32'h00028BE6;  13: t = 32'h000145F3;
      14: t = 32'h0000A2FA;  15: t = 32'h0000517D;
      16: t = 32'h000028BE;  17: t = 32'h0000145F;
      18: t = 32'h00000A30;  19: t = 32'h00000518;
      20: t = 32'h0000028C;  21: t = 32'h00000146;
      22: t = 32'h000000A3;  23: t = 32'h00000051;
      24: t = 32'h00000029;  25: t = 32'h00000014;
      26: t = 32'h0000000A;  27: t = 32'h00000005;
      28: t = 32'h00000003;  29: t = 32'h00000001;
      30: t = 32'h00000001;
      default: t = 32'h00000000;
    endcase
    if (angle_w >= 32) begin
      v = {32'd0, t} << (angle_w - 32);
    end else begin
      v = ({32'd0, t} + (64'd1 << (31 - angle_w))) >> (32 - angle_w);
    end
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cordic_stage.sv
// ============================================================================
//  Module      : cordic_stage
//  Description : One registered CORDIC micro-rotation by atan(2^-SHIFT) with
//                a global hold enable. Carries the per-sample mode bit when
//                CORDIC_VECTOR_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cordic_stage
  import cordic_pkg::*;
#(
  parameter int SHIFT   = 0,
  parameter int XY_W    = 34,
  parameter int ANGLE_W = 32
) (
  input  logic                      clock,
  input  logic                      rst_n,
  input  logic                      i_en,
  input  logic                      i_valid,
  input  logic signed [XY_W-1:0]    i_x,
  input  logic signed [XY_W-1:0]    i_y,
  input  logic        [ANGLE_W-1:0] i_z,
`ifdef CORDIC_VECTOR_EN
  input  cordic_mode_e              i_mode,
  output cordic_mode_e              o_mode,
`endif
  output logic                      o_valid,
  output logic signed [XY_W-1:0]    o_x,
  output logic signed [XY_W-1:0]    o_y,
  output logic        [ANGLE_W-1:0] o_z
);

  localparam logic [63:0]        c_atan_full = atan_lut(SHIFT, ANGLE_W);
  localparam logic [ANGLE_W-1:0] c_atan      = c_atan_full[ANGLE_W-1:0];

  logic signed [XY_W-1:0] w_x_sh;
  logic signed [XY_W-1:0] w_y_sh;
  logic                   w_neg;

  assign w_x_sh = i_x >>> SHIFT;
  assign w_y_sh = i_y >>> SHIFT;

  // Direction select: w_neg means d = -1
  always_comb begin
    w_neg = i_z[ANGLE_W-1];
`ifdef CORDIC_VECTOR_EN
    if (i_mode == CORDIC_VEC) begin
      w_neg = ~i_y[XY_W-1];
    end
`endif
  end

  // Micro-rotation register, frozen while the pipeline is stalled
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      o_valid <= 1'b0;
      o_x     <= '0;
      o_y     <= '0;
      o_z     <= '0;
`ifdef CORDIC_VECTOR_EN
      o_mode  <= CORDIC_ROT;
`endif
    end else if (i_en) begin
      o_valid <= i_valid;
      if (w_neg) begin
        o_x <= i_x + w_y_sh;
        o_y <= i_y - w_x_sh;
        o_z <= i_z + c_atan;
      end else begin
        o_x <= i_x - w_y_sh;
        o_y <= i_y + w_x_sh;
        o_z <= i_z - c_atan;
      end
`ifdef CORDIC_VECTOR_EN
      o_mode <= i_mode;
`endif
    end
  end

endmodule

`default_nettype wire

// File: rtl/cordic_pipe.sv
// ============================================================================
//  Module      : cordic_pipe
//  Description : Fully pipelined CORDIC engine with valid/ready streaming.
//                Stage P (quadrant pre-rotation), ITER micro-rotation stages,
//                stage O (saturation). Latency ITER+2 clocks, 1 sample/clock.
//                Optional feature macro: CORDIC_VECTOR_EN adds the in_mode
//                port and vectoring mode.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cordic_pipe
  import cordic_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ANGLE_W = 32,
  parameter int ITER    = 16
) (
  input  logic                      clock,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [DATA_W-1:0]  in_x,
  input  logic signed [DATA_W-1:0]  in_y,
  input  logic        [ANGLE_W-1:0] in_z,
`ifdef CORDIC_VECTOR_EN
  input  logic                      in_mode,
`endif
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [DATA_W-1:0]  out_x,
  output logic signed [DATA_W-1:0]  out_y,
  output logic        [ANGLE_W-1:0] out_z
);

  // Two guard bits: CORDIC gain (~1.65) plus negation of the most negative input
  localparam int c_xy_w = DATA_W + 2;

  logic                      w_adv;
  logic signed [c_xy_w-1:0]  w_x_ext;
  logic signed [c_xy_w-1:0]  w_y_ext;
  logic        [ANGLE_W-1:0] w_z_pi;
  logic                      w_pre;

  logic                      r_p_valid;
  logic signed [c_xy_w-1:0]  r_p_x;
  logic signed [c_xy_w-1:0]  r_p_y;
  logic        [ANGLE_W-1:0] r_p_z;

  logic                      w_sv [0:ITER];
  logic signed [c_xy_w-1:0]  w_sx [0:ITER];
  logic signed [c_xy_w-1:0]  w_sy [0:ITER];
  logic        [ANGLE_W-1:0] w_sz [0:ITER];

  logic                      r_out_valid;
  logic signed [DATA_W-1:0]  r_out_x;
  logic signed [DATA_W-1:0]  r_out_y;
  logic        [ANGLE_W-1:0] r_out_z;

`ifdef CORDIC_VECTOR_EN
  cordic_mode_e              r_p_mode;
  cordic_mode_e              w_sm [0:ITER];
  cordic_mode_e              w_unused_mode;
`endif

  // Clamp the widened datapath back into the DATA_W signed range
  function automatic logic signed [DATA_W-1:0] f_sat(input logic signed [c_xy_w-1:0] v);
    logic [2:0] top;
    top = v[c_xy_w-1:DATA_W-1];
    if (top == 3'b000 || top == 3'b111) begin
      return v[DATA_W-1:0];
    end else if (v[c_xy_w-1]) begin
      return {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      return {1'b0, {(DATA_W-1){1'b1}}};
    end
  endfunction

  // The whole pipeline moves as one; a stalled full output freezes every stage
  assign w_adv    = !r_out_valid | out_ready;
  assign in_ready = w_adv;

  assign w_x_ext = {{2{in_x[DATA_W-1]}}, in_x};
  assign w_y_ext = {{2{in_y[DATA_W-1]}}, in_y};
  assign w_z_pi  = {~in_z[ANGLE_W-1], in_z[ANGLE_W-2:0]};

  // Pre-rotation decision: fold phases in (pi/2, 3pi/2) or vectors with x<0 by pi
  always_comb begin
    w_pre = in_z[ANGLE_W-1] ^ in_z[ANGLE_W-2];
`ifdef CORDIC_VECTOR_EN
    if (in_mode) begin
      w_pre = in_x[DATA_W-1];
    end
`endif
  end

  // Stage P register
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_p_valid <= 1'b0;
      r_p_x     <= '0;
      r_p_y     <= '0;
      r_p_z     <= '0;
`ifdef CORDIC_VECTOR_EN
      r_p_mode  <= CORDIC_ROT;
`endif
    end else if (w_adv) begin
      r_p_valid <= in_valid;
      r_p_x     <= w_pre ? -w_x_ext : w_x_ext;
      r_p_y     <= w_pre ? -w_y_ext : w_y_ext;
      r_p_z     <= w_pre ? w_z_pi : in_z;
`ifdef CORDIC_VECTOR_EN
      r_p_mode  <= cordic_mode_e'(in_mode);
`endif
    end
  end

  assign w_sv[0] = r_p_valid;
  assign w_sx[0] = r_p_x;
  assign w_sy[0] = r_p_y;
  assign w_sz[0] = r_p_z;
`ifdef CORDIC_VECTOR_EN
  assign w_sm[0]       = r_p_mode;
  assign w_unused_mode = w_sm[ITER];
`endif

  for (genvar gi = 0; gi < ITER; gi++) begin : g_stage
    cordic_stage #(
      .SHIFT   (gi),
      .XY_W    (c_xy_w),
      .ANGLE_W (ANGLE_W)
    ) u_stage (
      .clock   (clock),
      .rst_n   (rst_n),
      .i_en    (w_adv),
      .i_valid (w_sv[gi]),
      .i_x     (w_sx[gi]),
      .i_y     (w_sy[gi]),
      .i_z     (w_sz[gi]),
`ifdef CORDIC_VECTOR_EN
      .i_mode  (w_sm[gi]),
      .o_mode  (w_sm[gi+1]),
`endif
      .o_valid (w_sv[gi+1]),
      .o_x     (w_sx[gi+1]),
      .o_y     (w_sy[gi+1]),
      .o_z     (w_sz[gi+1])
    );
  end

  // Stage O register: saturate x/y, pass the angle through
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_x     <= '0;
      r_out_y     <= '0;
      r_out_z     <= '0;
    end else if (w_adv) begin
      r_out_valid <= w_sv[ITER];
      r_out_x     <= f_sat(w_sx[ITER]);
      r_out_y     <= f_sat(w_sy[ITER]);
      r_out_z     <= w_sz[ITER];
    end
  end

  assign out_valid = r_out_valid;
  assign out_x     = r_out_x;
  assign out_y     = r_out_y;
  assign out_z     = r_out_z;

endmodule

`default_nettype wire

// File: tb/tb_cordic_pipe.sv
// ============================================================================
//  Module      : tb_cordic_pipe
//  Description : Scoreboard bench for cordic_pipe (DATA_W=32, ANGLE_W=32,
//                ITER=16). Build with CORDIC_VECTOR_EN to add vectoring cases.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cordic_pipe;

  localparam int     DW = 32;
  localparam int     AW = 32;
  localparam int     IT = 16;
  localparam real    PI = 3.14159265358979323846;
  // Residual angle after 16 stages is at most atan(2^-15) rad, i.e. ~32768 LSB
  // on a 2^30-amplitude vector; a little extra covers shift truncation.
  localparam longint TOL_XY   = 33792;
  localparam longint TOL_WIDE = 262144;
  localparam longint TOL_Z    = 131072;
  localparam logic signed [31:0] X0 = 32'sh26DD3B6A;

  typedef struct {
    longint ex;
    longint ey;
    longint ez;
    longint txy_x;
    longint txy_y;
    longint tz;
    int     cin;
    bit     lat;
  } exp_t;

  logic                 clock = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_x;
  logic signed [DW-1:0] in_y;
  logic        [AW-1:0] in_z;
`ifdef CORDIC_VECTOR_EN
  logic                 in_mode;
`endif
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic signed [DW-1:0] out_x;
  logic signed [DW-1:0] out_y;
  logic        [AW-1:0] out_z;

  exp_t sbq[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  bit   rnd_ready = 1'b0;
  bit   fix_ready = 1'b1;
  real  kg;

  cordic_pipe #(.DATA_W(DW), .ANGLE_W(AW), .ITER(IT)) dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_z      (in_z),
`ifdef CORDIC_VECTOR_EN
    .in_mode   (in_mode),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_x     (out_x),
    .out_y     (out_y),
    .out_z     (out_z)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Downstream ready: fixed level or random back-pressure
  initial begin
    forever begin
      @(posedge clock);
      #1;
      out_ready = rnd_ready ? ($urandom_range(0, 1) == 1) : fix_ready;
    end
  end

  task automatic chk(input string nm, input longint act, input longint req, input longint tol);
    longint d;
    d = act - req;
    if (d < 0) d = -d;
    n_chk++;
    if (d > tol) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d (tol %0d) t=%0t", nm, act, req, tol, $time);
    end
  endtask

  task automatic chk_z(input longint act, input longint req, input longint tol);
    logic [31:0] dw;
    longint      d;
    dw = act[31:0] - req[31:0];
    d  = longint'($signed(dw));
    if (d < 0) d = -d;
    n_chk++;
    if (d > tol) begin
      n_fail++;
      $display("FAIL out_z: actual 0x%08h required 0x%08h (tol %0d) t=%0t", act[31:0], req[31:0], tol, $time);
    end
  endtask

  function automatic real gain16();
    real r;
    r = 1.0;
    for (int i = 0; i < IT; i++) r = r * $sqrt(1.0 + 1.0 / real'(longint'(1) << (2 * i)));
    return r;
  endfunction

  function automatic exp_t mk(input longint ex, input longint ey, input longint ez,
                              input longint tx, input longint ty, input longint tz, input bit lat);
    exp_t e;
    e.ex = ex; e.ey = ey; e.ez = ez;
    e.txy_x = tx; e.txy_y = ty; e.tz = tz;
    e.cin = 0; e.lat = lat;
    return e;
  endfunction

  // Real-valued rotation reference for the streamed phases
  function automatic exp_t rot_model(input longint x, input longint y, input logic [31:0] z);
    real th, c, s;
    th = real'(z) / 4294967296.0 * 2.0 * PI;
    c  = $cos(th);
    s  = $sin(th);
    return mk(longint'(kg * (real'(x) * c - real'(y) * s)),
              longint'(kg * (real'(x) * s + real'(y) * c)), 0, TOL_XY, TOL_XY, TOL_Z, 1'b0);
  endfunction

  // Present one sample; called #1 after a rising edge, returns #1 after the accepting edge
  task automatic send(input logic signed [31:0] x, input logic signed [31:0] y,
                      input logic [31:0] z, input bit mode, input exp_t e);
    bit done;
    int w;
    done = 1'b0;
    w    = 0;
    in_valid = 1'b1;
    in_x = x; in_y = y; in_z = z;
`ifdef CORDIC_VECTOR_EN
    in_mode = mode;
`else
    if (mode) $display("vectoring sample skipped in rotation-only build");
`endif
    while (!done && w < 300) begin
      @(negedge clock);
      if (in_ready) begin
        e.cin = cyc;
        done  = 1'b1;
      end
      @(posedge clock);
      #1;
      w++;
    end
    if (done) sbq.push_back(e);
    else chk("accept_timeout", 0, 1, 0);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 600 && sbq.size() != 0; k++) @(posedge clock);
    chk("drain_queue_empty", longint'(sbq.size()), 0, 0);
    @(posedge clock);
    #1;
  endtask

  // Monitor: protocol, stall stability and scoreboard comparison
  initial begin
    exp_t                 e;
    logic                 p_v, p_r, p_rst;
    logic signed [DW-1:0] p_x, p_y;
    logic        [AW-1:0] p_z;
    p_v = 1'b0; p_r = 1'b1; p_rst = 1'b0;
    p_x = '0; p_y = '0; p_z = '0;
    forever begin
      @(negedge clock);
      if (rst_n && p_rst) begin
        chk("in_ready_rule", longint'(in_ready), longint'(!out_valid | out_ready), 0);
        if (p_v && !p_r) begin
          chk("stall_valid", longint'(out_valid), 1, 0);
          chk("stall_x", longint'(out_x), longint'(p_x), 0);
          chk("stall_y", longint'(out_y), longint'(p_y), 0);
          chk("stall_z", longint'(out_z), longint'(p_z), 0);
        end
        if (out_valid && out_ready) begin
          if (sbq.size() == 0) begin
            chk("unexpected_output", 1, 0, 0);
          end else begin
            e = sbq.pop_front();
            chk("out_x", longint'(out_x), e.ex, e.txy_x);
            chk("out_y", longint'(out_y), e.ey, e.txy_y);
            chk_z(longint'(out_z), e.ez, e.tz);
            if (e.lat) chk("latency", longint'(cyc - e.cin), 18, 0);
          end
        end
      end
      p_v = out_valid; p_r = out_ready; p_rst = rst_n;
      p_x = out_x; p_y = out_y; p_z = out_z;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    kg = gain16();
    in_valid = 1'b0; in_x = '0; in_y = '0; in_z = '0;
`ifdef CORDIC_VECTOR_EN
    in_mode = 1'b0;
`endif
    repeat (3) @(posedge clock);
    #1;
    chk("reset_out_valid", longint'(out_valid), 0, 0);
    chk("reset_out_x", longint'(out_x), 0, 0);
    chk("reset_out_y", longint'(out_y), 0, 0);
    chk("reset_out_z", longint'(out_z), 0, 0);
    #2 rst_n = 1'b1;
    @(posedge clock);
    #1;
    chk("reset_in_ready", longint'(in_ready), 1, 0);

    // Unit vector at 0 rad, latency checked
    send(X0, 0, 32'h00000000, 1'b0, mk(64'sh40000000, 0, 0, TOL_XY, TOL_XY, TOL_Z, 1'b1));
    drain();

    // 45 and 270 degrees
    send(X0, 0, 32'h20000000, 1'b0, mk(64'sh2D413CCD, 64'sh2D413CCD, 0, TOL_XY, TOL_XY, TOL_Z, 1'b0));
    send(X0, 0, 32'hC0000000, 1'b0, mk(0, -64'sh40000000, 0, TOL_XY, TOL_XY, TOL_Z, 1'b0));
    // Pre-rotation region and its phase boundaries
    send(X0, 0, 32'h80000000, 1'b0, mk(-64'sh40000000, 0, 0, TOL_XY, TOL_XY, TOL_Z, 1'b0));
    send(X0, 0, 32'h7FFFFFFF, 1'b0, mk(-64'sh40000000, 2, 0, TOL_XY, TOL_XY, TOL_Z, 1'b0));
    send(X0, 0, 32'h40000000, 1'b0, mk(0, 64'sh40000000, 0, TOL_XY, TOL_XY, TOL_Z, 1'b0));
    // Gain pushes full-scale inputs past range: output clamps exactly
    send(32'sh7FFFFFFF, 0, 32'h00000000, 1'b0, mk(64'sh7FFFFFFF, 0, 0, 0, TOL_WIDE, TOL_Z, 1'b0));
    send(32'sh80000000, 0, 32'h00000000, 1'b0, mk(-64'sh80000000, 0, 0, 0, TOL_WIDE, TOL_Z, 1'b0));
    drain();

    // Back-to-back stream under random back-pressure
    rnd_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      logic [31:0] z;
      z = $urandom();
      send(X0, 0, z, 1'b0, rot_model(longint'(X0), 0, z));
    end
    rnd_ready = 1'b0;
    fix_ready = 1'b1;
    drain();

    // Fill the pipeline with the output stalled, then reset asynchronously
    fix_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    for (int i = 0; i < 18; i++) begin
      send(X0, 0, 32'(i) << 24, 1'b0, mk(0, 0, 0, 0, 0, 0, 1'b0));
    end
    @(negedge clock);
    chk("full_out_valid", longint'(out_valid), 1, 0);
    chk("full_in_ready", longint'(in_ready), 0, 0);
    @(posedge clock);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", longint'(out_valid), 0, 0);
    chk("async_rst_out_x", longint'(out_x), 0, 0);
    chk("async_rst_out_y", longint'(out_y), 0, 0);
    chk("async_rst_out_z", longint'(out_z), 0, 0);
    sbq.delete();
    repeat (2) @(posedge clock);
    #3 rst_n = 1'b1;
    fix_ready = 1'b1;
    @(posedge clock);
    #1;
    send(X0, 0, 32'h20000000, 1'b0, mk(64'sh2D413CCD, 64'sh2D413CCD, 0, TOL_XY, TOL_XY, TOL_Z, 1'b1));
    drain();

`ifdef CORDIC_VECTOR_EN
    // Vectoring: magnitude (with gain) in x, angle accumulated into z
    send(32'sh20000000, 32'sh20000000, 32'h0, 1'b1,
         mk(longint'(kg * $sqrt(2.0) * 536870912.0), 0, 64'h20000000, 1024, TOL_WIDE, TOL_Z, 1'b0));
    send(-32'sh20000000, 0, 32'h0, 1'b1,
         mk(longint'(kg * 536870912.0), 0, 64'h80000000, 1024, TOL_WIDE, TOL_Z, 1'b0));
    drain();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
